// File: rtl/eth_ctrl_pkg.sv
// rtl/eth_ctrl_pkg.sv - shared types and constants for the Ethernet control path
package eth_ctrl_pkg;

   localparam int         CNT_W_DEF     = 24;
   localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_LOCK   = 3'd1,
      ST_PHY_RST     = 3'd2,
      ST_PHY_SETTLE  = 3'd3,
      ST_MAC_RELEASE = 3'd4,
      ST_RUN         = 3'd5,
      ST_FAULT       = 3'd6
   } bringup_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/phy_bringup_ctrl.sv
// rtl/phy_bringup_ctrl.sv - RGMII PHY/MAC power-up and recovery sequencer
// PHY_INT_MON_EN adds a PHY interrupt falling-edge pulse while in RUN.
module phy_bringup_ctrl
   import eth_ctrl_pkg::*;
#(
   parameter int RST_CYCLES      = 1000000,
   parameter int SETTLE_CYCLES   = 5000000,
   parameter int MAC_HOLD_CYCLES = 16,
   parameter int LOCK_TIMEOUT    = 10000000,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       mmcmLockedIn,
   input  logic       intBIn,
   input  logic       restartIn,
   output logic       phyRstBOut,
   output logic       macRstOut,
   output logic       linkReadyOut,
   output logic       faultOut,
   output logic [2:0] stateOut,
   output logic [7:0] lockLossCntOut,
   output logic       intPulseOut
);

   localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(MAC_HOLD_CYCLES - 1);

   bringup_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       llc_q, llc_d;
   logic             phy_rst_b_q, mac_rst_q, link_q, fault_q;
   logic             lock;
   logic             in_seq;

   sync_2ff u_lock_sync (
      .clk_i (clkIn),
      .rst_i (rstIn),
      .d_i   (mmcmLockedIn),
      .q_o   (lock)
   );

   assign in_seq = state_q inside {ST_PHY_RST, ST_PHY_SETTLE, ST_MAC_RELEASE, ST_RUN};

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      llc_d   = llc_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
         end
         ST_WAIT_LOCK: begin
            if (lock) begin
               state_d = ST_PHY_RST;
               cnt_d   = RST_LOAD;
            end else if (restartIn) begin
               cnt_d   = LOCK_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ST_FAULT;
            end
         end
         ST_PHY_RST: if (cnt_q == '0) begin
            state_d = ST_PHY_SETTLE;
            cnt_d   = SETTLE_LOAD;
         end
         ST_PHY_SETTLE: if (cnt_q == '0) begin
            state_d = ST_MAC_RELEASE;
            cnt_d   = HOLD_LOAD;
         end
         ST_MAC_RELEASE: if (cnt_q == '0) state_d = ST_RUN;
         ST_RUN: ;
         ST_FAULT: if (restartIn) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
      // Aborts override any counter expiry in the same cycle; lock loss wins over restart.
      if (in_seq && (!lock || restartIn)) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = LOCK_LOAD;
         if (!lock && llc_q != LOCK_LOSS_MAX) llc_d = llc_q + 8'd1;
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         llc_q       <= '0;
         phy_rst_b_q <= 1'b0;
         mac_rst_q   <= 1'b1;
         link_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         llc_q       <= llc_d;
         phy_rst_b_q <= state_d inside {ST_PHY_SETTLE, ST_MAC_RELEASE, ST_RUN};
         mac_rst_q   <= !(state_d inside {ST_MAC_RELEASE, ST_RUN});
         link_q      <= (state_d == ST_RUN);
         fault_q     <= (state_d == ST_FAULT);
      end
   end

   assign phyRstBOut     = phy_rst_b_q;
   assign macRstOut      = mac_rst_q;
   assign linkReadyOut   = link_q;
   assign faultOut       = fault_q;
   assign stateOut       = state_q;
   assign lockLossCntOut = llc_q;

`ifdef PHY_INT_MON_EN
   logic int_b_sync;
   logic int_hist_q;
   logic int_pulse_q;

   sync_2ff u_int_sync (
      .clk_i (clkIn),
      .rst_i (rstIn),
      .d_i   (intBIn),
      .q_o   (int_b_sync)
   );

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         int_hist_q  <= 1'b0;
         int_pulse_q <= 1'b0;
      end else begin
         int_hist_q  <= int_b_sync;
         int_pulse_q <= (state_q == ST_RUN) && int_hist_q && !int_b_sync;
      end
   end

   assign intPulseOut = int_pulse_q;
`else
   logic unused_int_b;
   assign unused_int_b = intBIn;
   assign intPulseOut  = 1'b0;
`endif

endmodule

// File: tb/tb_phy_bringup_ctrl.sv
// tb/tb_phy_bringup_ctrl.sv - directed table-driven bench for phy_bringup_ctrl
module tb_phy_bringup_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock_in;
   logic       int_b;
   logic       restart;
   logic       phy_rst_b;
   logic       mac_rst;
   logic       link_ready;
   logic       fault;
   logic [2:0] state;
   logic [7:0] llc;
   logic       int_pulse;

   int total = 0;
   int bad   = 0;
   int int_pulses = 0;

   phy_bringup_ctrl #(
      .RST_CYCLES      (10),
      .SETTLE_CYCLES   (20),
      .MAC_HOLD_CYCLES (4),
      .LOCK_TIMEOUT    (50),
      .CNT_W           (24)
   ) dut (
      .clkIn          (clk),
      .rstIn          (rst),
      .mmcmLockedIn   (lock_in),
      .intBIn         (int_b),
      .restartIn      (restart),
      .phyRstBOut     (phy_rst_b),
      .macRstOut      (mac_rst),
      .linkReadyOut   (link_ready),
      .faultOut       (fault),
      .stateOut       (state),
      .lockLossCntOut (llc),
      .intPulseOut    (int_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (int_pulse) int_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      int         wait_cyc;
      logic       lock;
      logic [2:0] st;
      logic       phy;
      logic       mac;
      logic       link;
      logic       flt;
      logic [7:0] llc;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int st, input int phy, input int mac,
                          input int link, input int flt, input int cnt);
      chk({name, ".state"}, int'(state), st);
      chk({name, ".phyRstB"}, int'(phy_rst_b), phy);
      chk({name, ".macRst"}, int'(mac_rst), mac);
      chk({name, ".linkReady"}, int'(link_ready), link);
      chk({name, ".fault"}, int'(fault), flt);
      chk({name, ".lockLossCnt"}, int'(llc), cnt);
   endtask

   int snap;

   initial begin
      vecs[0]  = '{1,   1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{28,  1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{2,   1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1,   1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{9,   1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1,   1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{19,  1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{1,   1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{3,   1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{1,   1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[10] = '{100, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[11] = '{2,   1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[12] = '{1,   1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[13] = '{3,   1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[14] = '{10,  1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[15] = '{20,  1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
      vecs[16] = '{4,   1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};

      rst = 1'b1; lock_in = 1'b0; int_b = 1'b1; restart = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("reset", 0, 0, 1, 0, 0, 0);
      chk("reset.intPulse", int'(int_pulse), 0);
      rst = 1'b0;

      // Nominal bring-up, lock loss in RUN and full re-sequence.
      for (int i = 0; i < 17; i++) begin
         lock_in = vecs[i].lock;
         repeat (vecs[i].wait_cyc) @(negedge clk);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].phy), int'(vecs[i].mac),
                 int'(vecs[i].link), int'(vecs[i].flt), int'(vecs[i].llc));
      end

      // Restart alone from RUN is not counted.
      restart = 1'b1; @(negedge clk); restart = 1'b0;
      chk_all("restart_only", 1, 0, 1, 0, 0, 1);
      @(negedge clk);
      chk("restart_only.phy_rst", int'(state), 2);
      repeat (10) @(negedge clk);
      chk_all("settle", 3, 1, 1, 0, 0, 1);

      // Restart and lock loss seen in the same PHY_SETTLE cycle.
      lock_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("both.pre", int'(state), 3);
      restart = 1'b1; @(negedge clk); restart = 1'b0;
      chk_all("both", 1, 0, 1, 0, 0, 2);

      // Lock arrives on the timeout edge.
      repeat (47) @(negedge clk);
      chk("lock_tmo.wait", int'(state), 1);
      lock_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("lock_tmo.last", int'(state), 1);
      @(negedge clk);
      chk_all("lock_tmo", 2, 0, 1, 0, 0, 2);

      // Genuine timeout into FAULT, then restart out of it.
      lock_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("tmo.entry", 1, 0, 1, 0, 0, 3);
      repeat (49) @(negedge clk);
      chk_all("tmo.before", 1, 0, 1, 0, 0, 3);
      @(negedge clk);
      chk_all("tmo.fault", 6, 0, 1, 0, 1, 3);
      lock_in = 1'b1;
      repeat (3) @(negedge clk);
      chk_all("fault.hold", 6, 0, 1, 0, 1, 3);
      restart = 1'b1; @(negedge clk); restart = 1'b0;
      chk_all("fault.exit", 1, 0, 1, 0, 0, 3);
      @(negedge clk);
      chk("fault.phy_rst", int'(state), 2);
      repeat (34) @(negedge clk);
      chk_all("fault.run", 5, 1, 0, 1, 0, 3);

      // Lock-loss counter saturation.
      for (int i = 0; i < 256; i++) begin
         lock_in = 1'b0; repeat (5) @(negedge clk);
         lock_in = 1'b1; repeat (5) @(negedge clk);
      end
      chk("sat.count", int'(llc), 255);
      chk("sat.state", int'(state), 2);
      repeat (9) @(negedge clk);
      chk("sat.settle", int'(state), 3);

      // Asynchronous reset in PHY_SETTLE.
      #2 rst = 1'b1;
      #1;
      chk_all("mid_rst", 0, 0, 1, 0, 0, 0);
      chk("mid_rst.intPulse", int'(int_pulse), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rerun.wait", int'(state), 1);
      repeat (2) @(negedge clk);
      chk_all("rerun.phy_rst", 2, 0, 1, 0, 0, 0);
      repeat (10) @(negedge clk);
      chk("rerun.settle", int'(state), 3);

      // Interrupt outside RUN is discarded.
      snap = int_pulses;
      int_b = 1'b0; repeat (2) @(negedge clk);
      int_b = 1'b1; repeat (8) @(negedge clk);
      chk("int.settle_pulses", int_pulses - snap, 0);
      chk("int.settle_state", int'(state), 3);
      repeat (14) @(negedge clk);
      chk_all("rerun.run", 5, 1, 0, 1, 0, 0);

      snap = int_pulses;
      int_b = 1'b0; repeat (2) @(negedge clk);
      int_b = 1'b1; repeat (8) @(negedge clk);
`ifdef PHY_INT_MON_EN
      chk("int.run_pulses", int_pulses - snap, 1);
`else
      chk("int.run_pulses", int_pulses - snap, 0);
      chk("int.total_pulses", int_pulses, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
